// File: rtl/operand_pairer_pkg.sv
// Shared defaults and derived widths for the operand pairer and its side FIFOs.
package operand_pairer_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefCntW  = 16;

  // Pointers index DEPTH entries; the level needs one more bit to represent "full".
  localparam int unsigned DefPtrW = $clog2(DefDepth);
  localparam int unsigned DefLvlW = DefPtrW + 1;

endpackage

// File: rtl/operand_pairer_stream_fifo.sv
// Single-side stream FIFO: stb/ack push, combinational head, level-based full/empty.
module stream_fifo
  import operand_pairer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     push_stb_i,
  output logic                     push_ack_o,
  output logic [WIDTH-1:0]         head_o,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full;
  logic             push;
  logic             pop;

  // Fullness alone gates the push; a same-edge pop never frees a slot early.
  assign full       = (level_q == LvlW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign push_ack_o = !full;
  assign push       = push_stb_i && !full;
  assign pop        = pop_i && !empty_o;
  assign head_o     = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = PtrW'(wr_ptr_q + 1'b1);
    if (pop)  rd_ptr_d = PtrW'(rd_ptr_q + 1'b1);
    case ({push, pop})
      2'b10:   level_d = LvlW'(level_q + 1'b1);
      2'b01:   level_d = LvlW'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
  end

  // Storage is cleared too so the head reads zero during and right after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/operand_pairer.sv
// Buffers two independent operand streams and issues them as (a, b) pairs in arrival order.
module operand_pairer
  import operand_pairer_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [WIDTH-1:0]       input_b,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  output logic [WIDTH-1:0]       output_a,
  output logic [WIDTH-1:0]       output_b,
  output logic                   output_ab_stb,
  input  logic                   output_ab_ack,
  output logic [CNT_W-1:0]       pair_count,
  output logic [$clog2(DEPTH):0] level_a,
  output logic [$clog2(DEPTH):0] level_b
);

  logic             empty_a, empty_b;
  logic             pop_pair;
  logic [CNT_W-1:0] pair_count_q, pair_count_d;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_data_i (input_a),
    .push_stb_i  (input_a_stb),
    .push_ack_o  (input_a_ack),
    .head_o      (output_a),
    .pop_i       (pop_pair),
    .level_o     (level_a),
    .empty_o     (empty_a)
  );

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_data_i (input_b),
    .push_stb_i  (input_b_stb),
    .push_ack_o  (input_b_ack),
    .head_o      (output_b),
    .pop_i       (pop_pair),
    .level_o     (level_b),
    .empty_o     (empty_b)
  );

  // Both heads must be present; ack without a valid pair is ignored.
  assign output_ab_stb = !empty_a && !empty_b;
  assign pop_pair      = output_ab_stb && output_ab_ack;
  assign pair_count    = pair_count_q;

  always_comb begin
    pair_count_d = pair_count_q;
    if (pop_pair) pair_count_d = CNT_W'(pair_count_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_count_q <= '0;
    end else begin
      pair_count_q <= pair_count_d;
    end
  end

endmodule

// File: tb/tb_operand_pairer.sv
// Directed bench for operand_pairer with a queue-based reference model of both side FIFOs.
module tb_operand_pairer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] input_a = '0;
  logic             input_a_stb = 1'b0;
  logic             input_a_ack;
  logic [WIDTH-1:0] input_b = '0;
  logic             input_b_stb = 1'b0;
  logic             input_b_ack;
  logic [WIDTH-1:0] output_a;
  logic [WIDTH-1:0] output_b;
  logic             output_ab_stb;
  logic             output_ab_ack = 1'b0;
  logic [CNT_W-1:0] pair_count;
  logic [LVL_W-1:0] level_a;
  logic [LVL_W-1:0] level_b;

  operand_pairer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .input_a       (input_a),
    .input_a_stb   (input_a_stb),
    .input_a_ack   (input_a_ack),
    .input_b       (input_b),
    .input_b_stb   (input_b_stb),
    .input_b_ack   (input_b_ack),
    .output_a      (output_a),
    .output_b      (output_b),
    .output_ab_stb (output_ab_stb),
    .output_ab_ack (output_ab_ack),
    .pair_count    (pair_count),
    .level_a       (level_a),
    .level_b       (level_b)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [CNT_W-1:0] cnt = '0;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; advances one cycle.
  task automatic step(output bit took_a, output bit took_b);
    bit pa, pb, pp;
    pa = input_a_stb && (qa.size() < DEPTH);
    pb = input_b_stb && (qb.size() < DEPTH);
    pp = (qa.size() > 0) && (qb.size() > 0) && output_ab_ack;
    chk("ack_a", 32'(input_a_ack), 32'(qa.size() < DEPTH));
    chk("ack_b", 32'(input_b_ack), 32'(qb.size() < DEPTH));
    chk("stb", 32'(output_ab_stb), 32'((qa.size() > 0) && (qb.size() > 0)));
    chk("level_a", 32'(level_a), 32'(qa.size()));
    chk("level_b", 32'(level_b), 32'(qb.size()));
    chk("count", 32'(pair_count), 32'(cnt));
    if (qa.size() > 0) chk("head_a", output_a, qa[0]);
    if (qb.size() > 0) chk("head_b", output_b, qb[0]);
    @(posedge clk);
    if (pp) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
      cnt = CNT_W'(cnt + 1'b1);
    end
    if (pa) qa.push_back(input_a);
    if (pb) qb.push_back(input_b);
    took_a = pa;
    took_b = pb;
    @(negedge clk);
  endtask

  task automatic cyc(input bit as, input logic [31:0] av, input bit bs, input logic [31:0] bv,
                     input bit ack);
    bit ta, tb;
    input_a_stb   = as;
    input_a       = av;
    input_b_stb   = bs;
    input_b       = bv;
    output_ab_ack = ack;
    step(ta, tb);
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_stb", 32'(output_ab_stb), 32'd0);
    chk("rst_level_a", 32'(level_a), 32'd0);
    chk("rst_level_b", 32'(level_b), 32'd0);
    chk("rst_count", 32'(pair_count), 32'd0);
    chk("rst_out_a", output_a, 32'd0);
    chk("rst_out_b", output_b, 32'd0);
    chk("rst_ack_a", 32'(input_a_ack), 32'd1);
    qa.delete();
    qb.delete();
    cnt = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit ta, tb, hold_a;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("inrst_stb", 32'(output_ab_stb), 32'd0);
    chk("inrst_ack_a", 32'(input_a_ack), 32'd1);
    chk("inrst_ack_b", 32'(input_b_ack), 32'd1);
    chk("inrst_out_a", output_a, 32'd0);
    rst = 1'b1;
    idle_drain(2);

    // Basic pair
    cyc(1'b1, 32'h3F80_0000, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1, 32'h4000_0000, 1'b1);
    chk("basic_stb", 32'(output_ab_stb), 32'd1);
    chk("basic_a", output_a, 32'h3F80_0000);
    chk("basic_b", output_b, 32'h4000_0000);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("basic_count", 32'(pair_count), 32'd1);

    // Skew and back-pressure
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i), 1'b0, '0, 1'b0);
    chk("skew_level_a", 32'(level_a), 32'd4);
    chk("skew_ack_a", 32'(input_a_ack), 32'd0);
    hold_a = 1'b1;
    for (int j = 0; j < 4; j++) begin
      input_a_stb   = hold_a;
      input_a       = 32'd5;
      input_b_stb   = 1'b1;
      input_b       = 32'(10 + j);
      output_ab_ack = 1'b1;
      step(ta, tb);
      if (ta) hold_a = 1'b0;
    end
    cyc(hold_a, 32'd5, 1'b1, 32'd14, 1'b1);
    idle_drain(6);
    chk("skew_count", 32'(pair_count), 32'd6);

    // Output stall with tail pushes
    cyc(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    cyc(1'b1, 32'h101, 1'b1, 32'h201, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(i < 2, 32'h300 + 32'(i), i < 2, 32'h202 + 32'(i), 1'b0);
    end
    chk("stall_head_a", output_a, 32'h100);
    chk("stall_head_b", output_b, 32'h200);
    chk("stall_stb", 32'(output_ab_stb), 32'd1);
    idle_drain(6);

    // Simultaneous push/pop, then refused push into a full side
    cyc(1'b1, 32'h400, 1'b1, 32'h500, 1'b0);
    cyc(1'b1, 32'h401, 1'b1, 32'h501, 1'b0);
    cyc(1'b1, 32'h402, 1'b1, 32'h502, 1'b1);
    chk("sim_level_a", 32'(level_a), 32'd2);
    chk("sim_level_b", 32'(level_b), 32'd2);
    chk("sim_head_a", output_a, 32'h401);
    cyc(1'b1, 32'h403, 1'b0, '0, 1'b0);
    cyc(1'b1, 32'h404, 1'b0, '0, 1'b0);
    cyc(1'b1, 32'h405, 1'b0, '0, 1'b1);
    chk("full_pop_level_a", 32'(level_a), 32'd3);
    chk("full_pop_head_a", output_a, 32'h402);
    cyc(1'b0, '0, 1'b1, 32'h503, 1'b1);
    cyc(1'b0, '0, 1'b1, 32'h504, 1'b1);
    idle_drain(4);

    // Reset mid-operation with 3 pairs queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h600 + 32'(i), 1'b1, 32'h700 + 32'(i), 1'b0);
    async_reset();
    cyc(1'b1, 32'h800, 1'b1, 32'h900, 1'b0);
    chk("post_rst_a", output_a, 32'h800);
    chk("post_rst_b", output_b, 32'h900);
    cyc(1'b0, '0, 1'b0, '0, 1'b1);
    chk("post_rst_count", 32'(pair_count), 32'd1);

    // Counter wrap: 17 pairs from a clean reset
    async_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 32'(i), 1'b1, 32'(i + 100), 1'b1);
    idle_drain(3);
    chk("wrap_count", 32'(pair_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_pairer.md
Name: operand_pairer

Overview:
- Downstream consumer of the stimulus file readers (file_reader_a and its twin on the b side).
- Accepts the two independent 32-bit stb/ack streams and buffers each in a small FIFO.
- Presents matched (a, b) operand pairs to the multiplier under a single stb/ack handshake.
- Decouples reader stalls from multiplier stalls; pairs are issued strictly in arrival order per side.

Parameters:
- WIDTH, 32: data width of each operand.
- DEPTH, 4: entries per side FIFO; power of two, minimum 2.
- CNT_W, 16: width of the issued-pair counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- input_a  in  WIDTH  a-operand data from the a-side file reader
- input_a_stb  in  1  a-operand valid
- input_a_ack  out  1  a-side FIFO can accept
- input_b  in  WIDTH  b-operand data from the b-side file reader
- input_b_stb  in  1  b-operand valid
- input_b_ack  out  1  b-side FIFO can accept
- output_a  out  WIDTH  head of the a-side FIFO
- output_b  out  WIDTH  head of the b-side FIFO
- output_ab_stb  out  1  pair valid
- output_ab_ack  in  1  multiplier accepts the pair
- pair_count  out  CNT_W  number of pairs issued since reset; wraps
- level_a  out  log2(DEPTH)+1  occupancy of the a-side FIFO
- level_b  out  log2(DEPTH)+1  occupancy of the b-side FIFO

Behaviour:
- Reset (rst=0, asynchronous): all pointers, levels and pair_count go to 0. Buffered data is discarded. Reset applies immediately, including mid-transfer.
- Outputs during reset: output_ab_stb=0, input_*_ack=1 (FIFOs empty), output_a/output_b=0.
- Push, per side: occurs on a rising edge where input_x_stb=1 and input_x_ack=1.
- input_x_ack = !full_x, combinational from the level.
- One push per edge. This is compatible with the reader dropping stb on the edge it sees ack.
- input_x_ack depends only on fullness. A push is never accepted while full, even if a pop happens on the same edge.
- output_ab_stb = !empty_a && !empty_b, combinational from the levels.
- output_a/output_b are combinational reads of the two FIFO heads. Read pointers are zero at reset, so heads read as entry 0.
- Pop: on an edge where output_ab_stb=1 and output_ab_ack=1, both read pointers advance together and pair_count increments, wrapping 2^CNT_W-1 -> 0.
- Ack while stb=0 is ignored: no pointer or counter change.
- Latency: data pushed at edge N appears at the output with output_ab_stb=1 after edge N, provided the other side is already non-empty. Minimum pass-through is 1 cycle.
- Simultaneous push and pop on a non-full side: the level is unchanged and both pointers advance.
- Push into an empty side while the other side is non-empty: the pair becomes valid on the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from a separate level counter (0..DEPTH), not from pointer comparison.
- Skew: one side may run up to DEPTH entries ahead. The faster side then stalls through ack=0; no data is lost or reordered.
- Held output: while output_ab_stb=1 and output_ab_ack=0, output_a/output_b stay stable. Pushes to the tails are allowed and must not alter the heads.
- No state machine beyond the FIFO control. The block is entirely handshake-driven.

Decomposition:
- Shared package: the WIDTH and DEPTH defaults, the clog2-derived pointer and level widths, and CNT_W.
- Sub-module stream_fifo (WIDTH, DEPTH) is instantiated twice, once for a and once for b.
  - stream_fifo interface: push data/stb/ack, combinational head, pop, level, empty, full.
  - It shares the same active-low asynchronous reset.
- The top level holds only the pair-valid logic, the joint pop and pair_count.

Test Plan:
- Reset then idle: rst low for 3 cycles, release -> output_ab_stb=0, input_a_ack=input_b_ack=1, pair_count=0, level_a=level_b=0.
- Basic pair:
  - Push a=0x3F800000 at edge 1, push b=0x40000000 at edge 3, ack held high -> output_ab_stb rises after edge 3.
  - Output shows (0x3F800000, 0x40000000); pops at edge 4; pair_count=1.
- Skew and back-pressure: push 5 a-values (1..5) with no b and ack=0 -> level_a=4 and input_a_ack=0 after the 4th push; value 5 is held at the reader. Then push b=10..13 with ack=1 -> pairs (1,10),(2,11),(3,12),(4,13) in order, then (5, next b).
- Output stall: 2 pairs buffered with ack=0 for 10 cycles -> output_a/output_b stable and stb high throughout; a pushes to the tail meanwhile do not change the head.
- Simultaneous push/pop: level_a=2, level_b=2, push a and b while popping on the same edge -> levels stay 2 and the heads advance by one; full-side push with a simultaneous pop is refused (ack=0).
- Reset mid-operation: rst asserted asynchronously between edges with 3 pairs queued -> stb drops immediately, levels and pair_count go to 0, and the next pair after release is the first one pushed after release.
- Counter wrap: with CNT_W=4, issue 17 pairs -> pair_count reads 1.
